// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation codes and
// instruction-type debug tags, also used by the control unit.
package ex_stage_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_NOR  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_LUI  = 4'b1011;

   // Bubbles carry this tag; it matches the cleared register value.
   localparam logic [3:0] INST_TYPE_NONE = 4'd0;

endpackage

// File: rtl/ex_stage_alu.sv
// Purely combinational ALU for the execute stage; shift amounts come
// from a[4:0] and the shifted value from b.
import ex_stage_pkg::*;

module alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  aluc,
   output logic [31:0] result,
   output logic        ovf
);

   always_comb begin
      result = 32'd0;
      ovf    = 1'b0;
      case (aluc)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'd0, a < b};
         ALU_SLL:  result = b << a[4:0];
         ALU_SRL:  result = b >> a[4:0];
         ALU_SRA:  result = $unsigned($signed(b) >>> a[4:0]);
         ALU_LUI:  result = {b[15:0], 16'd0};
         default:  result = 32'd0;
      endcase
      // Signed overflow is reported only for the arithmetic ops.
      if (aluc == ALU_ADD)
         ovf = (a[31] == b[31]) && (result[31] != a[31]);
      else if (aluc == ALU_SUB)
         ovf = (a[31] != b[31]) && (result[31] != a[31]);
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, operand muxes and ALU.
// ex_aluR is combinational from the EX registers so decode can forward it.
import ex_stage_pkg::*;

module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        cu_wreg,
   input  logic        cu_m2reg,
   input  logic        cu_wmem,
   input  logic [3:0]  cu_aluc,
   input  logic        cu_shift,
   input  logic        cu_aluimm,
   input  logic [31:0] id_inA,
   input  logic [31:0] id_inB,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_destR,
   input  logic [3:0]  ID_ins_type,
   input  logic [3:0]  ID_ins_number,
   output logic [31:0] ex_aluR,
   output logic [31:0] ex_inB,
   output logic [4:0]  ex_destR,
   output logic        ex_wreg,
   output logic        ex_m2reg,
   output logic        ex_wmem,
   output logic        ex_ovf,
   output logic [3:0]  EX_ins_type,
   output logic [3:0]  EX_ins_number
);

   logic [3:0]  aluc_r;
   logic        shift_r;
   logic        aluimm_r;
   logic [31:0] inA_r;
   logic [31:0] imm_r;
   logic [31:0] op_a;
   logic [31:0] op_b;

   // No enable and no stall: every edge loads whatever decode presents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_wreg       <= 1'b0;
         ex_m2reg      <= 1'b0;
         ex_wmem       <= 1'b0;
         aluc_r        <= 4'd0;
         shift_r       <= 1'b0;
         aluimm_r      <= 1'b0;
         inA_r         <= 32'd0;
         ex_inB        <= 32'd0;
         imm_r         <= 32'd0;
         ex_destR      <= 5'd0;
         EX_ins_type   <= 4'd0;
         EX_ins_number <= 4'd0;
      end else begin
         ex_wreg       <= cu_wreg;
         ex_m2reg      <= cu_m2reg;
         ex_wmem       <= cu_wmem;
         aluc_r        <= cu_aluc;
         shift_r       <= cu_shift;
         aluimm_r      <= cu_aluimm;
         inA_r         <= id_inA;
         ex_inB        <= id_inB;
         imm_r         <= id_imm;
         ex_destR      <= id_destR;
         EX_ins_type   <= ID_ins_type;
         EX_ins_number <= ID_ins_number;
      end
   end

   // Store data always leaves on ex_inB even when B takes the immediate.
   assign op_a = shift_r  ? {27'd0, imm_r[10:6]} : inA_r;
   assign op_b = aluimm_r ? imm_r : ex_inB;

   alu u_alu (
      .a      (op_a),
      .b      (op_b),
      .aluc   (aluc_r),
      .result (ex_aluR),
      .ovf    (ex_ovf)
   );

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push hand-computed
// results; a monitor pops and compares one cycle after each issue.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        cu_wreg, cu_m2reg, cu_wmem, cu_shift, cu_aluimm;
   logic [3:0]  cu_aluc;
   logic [31:0] id_inA, id_inB, id_imm;
   logic [4:0]  id_destR;
   logic [3:0]  ID_ins_type, ID_ins_number;
   logic [31:0] ex_aluR, ex_inB;
   logic [4:0]  ex_destR;
   logic        ex_wreg, ex_m2reg, ex_wmem, ex_ovf;
   logic [3:0]  EX_ins_type, EX_ins_number;

   logic        issue = 1'b0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      int          id;
      logic [31:0] aluR;
      logic [31:0] inB;
      logic [4:0]  destR;
      logic        wreg;
      logic        m2reg;
      logic        wmem;
      logic        ovf;
      logic [3:0]  itype;
      logic [3:0]  inum;
   } exp_t;

   exp_t sb[$];

   ex_stage dut (
      .clk           (clk),
      .rst           (rst),
      .cu_wreg       (cu_wreg),
      .cu_m2reg      (cu_m2reg),
      .cu_wmem       (cu_wmem),
      .cu_aluc       (cu_aluc),
      .cu_shift      (cu_shift),
      .cu_aluimm     (cu_aluimm),
      .id_inA        (id_inA),
      .id_inB        (id_inB),
      .id_imm        (id_imm),
      .id_destR      (id_destR),
      .ID_ins_type   (ID_ins_type),
      .ID_ins_number (ID_ins_number),
      .ex_aluR       (ex_aluR),
      .ex_inB        (ex_inB),
      .ex_destR      (ex_destR),
      .ex_wreg       (ex_wreg),
      .ex_m2reg      (ex_m2reg),
      .ex_wmem       (ex_wmem),
      .ex_ovf        (ex_ovf),
      .EX_ins_type   (EX_ins_type),
      .EX_ins_number (EX_ins_number)
   );

   always #5 clk = ~clk;

   task automatic cmp(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp(e.id, "aluR",   ex_aluR,               e.aluR);
      cmp(e.id, "inB",    ex_inB,                e.inB);
      cmp(e.id, "destR",  {27'd0, ex_destR},     {27'd0, e.destR});
      cmp(e.id, "wreg",   {31'd0, ex_wreg},      {31'd0, e.wreg});
      cmp(e.id, "m2reg",  {31'd0, ex_m2reg},     {31'd0, e.m2reg});
      cmp(e.id, "wmem",   {31'd0, ex_wmem},      {31'd0, e.wmem});
      cmp(e.id, "ovf",    {31'd0, ex_ovf},       {31'd0, e.ovf});
      cmp(e.id, "type",   {28'd0, EX_ins_type},  {28'd0, e.itype});
      cmp(e.id, "number", {28'd0, EX_ins_number},{28'd0, e.inum});
   endtask

   // Drives one decode word just after an edge; the next edge captures it.
   task automatic applyStimulus(
      input int id, input logic [3:0] aluc, input logic shift, input logic aluimm,
      input logic wreg, input logic m2reg, input logic wmem,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
      input logic [4:0] dest, input logic [3:0] itype, input logic [3:0] inum,
      input logic [31:0] exp_r, input logic exp_ovf);
      exp_t e;
      @(posedge clk);
      #2;
      cu_aluc = aluc; cu_shift = shift; cu_aluimm = aluimm;
      cu_wreg = wreg; cu_m2reg = m2reg; cu_wmem = wmem;
      id_inA = a; id_inB = b; id_imm = imm; id_destR = dest;
      ID_ins_type = itype; ID_ins_number = inum;
      issue = 1'b1;
      e.id = id; e.aluR = exp_r; e.inB = b; e.destR = dest;
      e.wreg = wreg; e.m2reg = m2reg; e.wmem = wmem; e.ovf = exp_ovf;
      e.itype = itype; e.inum = inum;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      if (issue && !rst) begin
         #1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got output with empty queue expected entry");
         end else begin
            checkOutput(sb.pop_front());
         end
      end
   end

   initial begin
      exp_t zero;
      zero = '{id: 0, aluR: 32'd0, inB: 32'd0, destR: 5'd0, wreg: 1'b0, m2reg: 1'b0,
               wmem: 1'b0, ovf: 1'b0, itype: 4'd0, inum: 4'd0};
      rst = 1'b1;
      cu_aluc = 4'd0; cu_shift = 1'b0; cu_aluimm = 1'b0;
      cu_wreg = 1'b0; cu_m2reg = 1'b0; cu_wmem = 1'b0;
      id_inA = 32'd0; id_inB = 32'd0; id_imm = 32'd0; id_destR = 5'd0;
      ID_ins_type = 4'd0; ID_ins_number = 4'd0;
      #3;
      checkOutput(zero);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      //             id aluc   sh ai wr m2 wm inA           inB           imm           dst   ty    num   result        ovf
      applyStimulus( 1, 4'd0,  0, 0, 1, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        5'd3, 4'd1, 4'd1, 32'h80000000, 1);
      applyStimulus( 2, 4'd1,  0, 0, 1, 0, 0, 32'h80000000, 32'h00000001, 32'h0,        5'd4, 4'd1, 4'd2, 32'h7FFFFFFF, 1);
      applyStimulus( 3, 4'd6,  0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd5, 4'd1, 4'd3, 32'h00000001, 0);
      applyStimulus( 4, 4'd7,  0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd6, 4'd1, 4'd4, 32'h00000000, 0);
      applyStimulus( 5, 4'd10, 1, 0, 1, 0, 0, 32'h12345678, 32'h80000000, 32'h00000100, 5'd7, 4'd2, 4'd5, 32'hF8000000, 0);
      applyStimulus( 6, 4'd9,  1, 0, 1, 0, 0, 32'h12345678, 32'h80000000, 32'h00000100, 5'd7, 4'd2, 4'd6, 32'h08000000, 0);
      applyStimulus( 7, 4'd0,  0, 1, 0, 0, 1, 32'h00000100, 32'hDEADBEEF, 32'hFFFFFFFC, 5'd0, 4'd3, 4'd7, 32'h000000FC, 0);
      applyStimulus( 8, 4'd2,  0, 0, 1, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd8, 4'd1, 4'd8, 32'hF000F000, 0);
      applyStimulus( 9, 4'd5,  0, 0, 1, 0, 0, 32'h00000000, 32'h00000000, 32'h0,        5'd8, 4'd1, 4'd9, 32'hFFFFFFFF, 0);
      applyStimulus(10, 4'd8,  0, 0, 1, 0, 0, 32'h00000020, 32'h00000001, 32'h0,        5'd9, 4'd2, 4'd10, 32'h00000001, 0);
      applyStimulus(11, 4'd12, 0, 0, 1, 0, 0, 32'h00000005, 32'h00000003, 32'h0,        5'd9, 4'd1, 4'd11, 32'h00000000, 0);
      applyStimulus(12, 4'd3,  0, 0, 1, 1, 0, 32'h0000F000, 32'h0000000F, 32'h0,        5'd10, 4'd4, 4'd12, 32'h0000F00F, 0);
      applyStimulus(13, 4'd0,  0, 0, 1, 0, 0, 32'h00400010, 32'h00000000, 32'h0,        5'd31, 4'd5, 4'd13, 32'h00400010, 0);
      applyStimulus(14, 4'd0,  0, 0, 1, 0, 0, 32'h00000005, 32'h00000007, 32'h0,        5'd8, 4'd1, 4'd14, 32'h0000000C, 0);
      applyStimulus(15, 4'd0,  0, 0, 0, 0, 0, 32'h00000000, 32'h00000000, 32'h0,        5'd0, 4'd0, 4'd0, 32'h00000000, 0);
      applyStimulus(16, 4'd11, 0, 1, 1, 0, 0, 32'h00000000, 32'h00000000, 32'h00001234, 5'd9, 4'd6, 4'd15, 32'h12340000, 0);
      applyStimulus(17, 4'd0,  0, 0, 1, 0, 0, 32'h00000001, 32'h00000002, 32'h0,        5'd12, 4'd2, 4'd15, 32'h00000003, 0);

      // Mid-stream asynchronous reset with wreg latched high.
      @(posedge clk);
      #1;
      issue = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      zero.id = 100;
      checkOutput(zero);
      @(posedge clk);
      #1;
      zero.id = 101;
      checkOutput(zero);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(18, 4'd4,  0, 0, 1, 0, 0, 32'h0000FFFF, 32'h00FF00FF, 32'h0,        5'd2, 4'd1, 4'd3, 32'h00FFFF00, 0);
      @(posedge clk);
      #2;
      issue = 1'b0;

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending entries expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
